// File: rtl/buf_ram_2p_pp_be.sv
// buf_ram_2p_pp_be
// Ping-pong two-port buffer RAM with two banks and lane-granular writes.
// The writer fills one bank while the reader drains the other. Bank
// ownership is passed with a done/ready handshake on each side.
//
// Ports:
//   clk, rst_n  - single rising-edge clock, synchronous active-low reset
//   a_we        - write mode: 00 none, 01 low half -> high lanes,
//                 10 low half -> low lanes, 11 full word under a_lmask
//   a_lmask     - per-lane enables used by write mode 11
//   a_addr      - write word address inside the writer bank
//   a_data_i    - write data, lane i at [PIXEL_WIDTH*(i+1)-1 : PIXEL_WIDTH*i]
//   a_done      - writer bank complete, hand it to the reader
//   a_rdy       - writer bank is empty; writes and a_done are accepted
//   b_re        - read request
//   b_addr      - read word address inside the reader bank
//   b_done      - reader bank consumed, release it
//   b_rdy       - reader bank is full; reads and b_done are accepted
//   b_data_o    - registered read data (one cycle latency)
//   b_valid_o   - b_data_o was refreshed this cycle
//   b_level     - number of full banks (0..2)
module buf_ram_2p_pp_be #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LANES       = 8,
    parameter int ADDR_WIDTH  = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   a_we,
    input  logic [LANES-1:0]             a_lmask,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    input  logic [PIXEL_WIDTH*LANES-1:0] a_data_i,
    input  logic                         a_done,
    output logic                         a_rdy,
    input  logic                         b_re,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    input  logic                         b_done,
    output logic                         b_rdy,
    output logic [PIXEL_WIDTH*LANES-1:0] b_data_o,
    output logic                         b_valid_o,
    output logic [1:0]                   b_level
);

    localparam int HALF   = LANES / 2;
    localparam int WORD_W = PIXEL_WIDTH * LANES;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    // Both banks live in one array; the bank pointer is the top address bit.
    logic [WORD_W-1:0] mem [0:2*DEPTH-1];

    logic [1:0]        full_q,    full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [WORD_W-1:0] b_data_q,  b_data_d;
    logic              b_valid_q, b_valid_d;

    logic [LANES-1:0]  lane_we;
    logic [WORD_W-1:0] lane_wdata;
    logic [ADDR_WIDTH:0] wr_index;
    logic [ADDR_WIDTH:0] rd_index;

    assign wr_index  = {wr_bank_q, a_addr};
    assign rd_index  = {rd_bank_q, b_addr};

    assign a_rdy     = ~full_q[wr_bank_q];
    assign b_rdy     = full_q[rd_bank_q];
    assign b_level   = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign b_data_o  = b_data_q;
    assign b_valid_o = b_valid_q;

    // Translate the write mode into per-lane enables and lane-aligned data.
    // Mode 01 is the only one that moves data between lanes; the others
    // write a_data_i in place. Writes are suppressed during reset and while
    // the writer bank is still owned by the reader.
    always_comb begin
        lane_we    = '0;
        lane_wdata = a_data_i;
        if (rst_n && a_rdy) begin
            case (a_we)
                2'b01: begin
                    for (int i = 0; i < HALF; i++) begin
                        lane_we[HALF+i] = 1'b1;
                        lane_wdata[(HALF+i)*PIXEL_WIDTH +: PIXEL_WIDTH] =
                            a_data_i[i*PIXEL_WIDTH +: PIXEL_WIDTH];
                    end
                end
                2'b10: begin
                    lane_we[HALF-1:0] = '1;
                end
                2'b11: begin
                    lane_we = a_lmask;
                end
                default: begin
                end
            endcase
        end
    end

    // Storage array; contents survive reset by design.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
                mem[wr_index][i*PIXEL_WIDTH +: PIXEL_WIDTH] <=
                    lane_wdata[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

    // Next-state for the read pipeline and the bank handshake. When both
    // sides hand over in the same cycle the pointers necessarily address
    // different banks, so the two full-flag updates never collide.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        b_data_d  = b_data_q;
        b_valid_d = 1'b0;

        if (b_re && b_rdy) begin
            b_data_d  = mem[rd_index];
            b_valid_d = 1'b1;
        end

        if (a_done && a_rdy) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end

        if (b_done && b_rdy) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            b_data_q  <= '0;
            b_valid_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            b_data_q  <= b_data_d;
            b_valid_q <= b_valid_d;
        end
    end

endmodule

// File: tb/tb_buf_ram_2p_pp_be.sv
module tb_buf_ram_2p_pp_be;

    localparam int PW    = 8;
    localparam int L     = 8;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk;
    logic          rst_n;
    logic [1:0]    a_we;
    logic [L-1:0]  a_lmask;
    logic [AW-1:0] a_addr;
    logic [63:0]   a_data_i;
    logic          a_done;
    logic          a_rdy;
    logic          b_re;
    logic [AW-1:0] b_addr;
    logic          b_done;
    logic          b_rdy;
    logic [63:0]   b_data_o;
    logic          b_valid_o;
    logic [1:0]    b_level;

    int total;
    int bad;

    // Reference model: a count of full banks plus which bank each side owns.
    int          mLevel;
    int          mWr;
    int          mRd;
    logic [63:0] mm [0:1][0:DEPTH-1];
    logic [63:0] expData;
    logic        expValid;

    buf_ram_2p_pp_be #(
        .PIXEL_WIDTH(PW),
        .LANES      (L),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_we     (a_we),
        .a_lmask  (a_lmask),
        .a_addr   (a_addr),
        .a_data_i (a_data_i),
        .a_done   (a_done),
        .a_rdy    (a_rdy),
        .b_re     (b_re),
        .b_addr   (b_addr),
        .b_done   (b_done),
        .b_rdy    (b_rdy),
        .b_data_o (b_data_o),
        .b_valid_o(b_valid_o),
        .b_level  (b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("a_rdy",     {63'd0, a_rdy},     {63'd0, (mLevel < 2)});
        checkVal("b_rdy",     {63'd0, b_rdy},     {63'd0, (mLevel > 0)});
        checkVal("b_level",   {62'd0, b_level},   64'(mLevel));
        checkVal("b_valid_o", {63'd0, b_valid_o}, {63'd0, expValid});
        checkVal("b_data_o",  b_data_o,           expData);
    endtask

    // Expected effect of one clock edge given the inputs about to be sampled.
    task automatic modelStep();
        logic [63:0] old;
        logic [63:0] bm;
        bit          canWrite;
        bit          canRead;
        if (!rst_n) begin
            mLevel   = 0;
            mWr      = 0;
            mRd      = 0;
            expData  = 64'd0;
            expValid = 1'b0;
        end else begin
            canWrite = (mLevel < 2);
            canRead  = (mLevel > 0);
            if (b_re && canRead) begin
                expData  = mm[mRd][b_addr];
                expValid = 1'b1;
            end else begin
                expValid = 1'b0;
            end
            if (canWrite && a_we != 2'b00) begin
                old = mm[mWr][a_addr];
                if (a_we == 2'b01) begin
                    mm[mWr][a_addr] = (old & 64'h0000_0000_FFFF_FFFF) | (a_data_i << 32);
                end else if (a_we == 2'b10) begin
                    mm[mWr][a_addr] = (old & 64'hFFFF_FFFF_0000_0000) | (a_data_i & 64'h0000_0000_FFFF_FFFF);
                end else begin
                    bm = 64'd0;
                    for (int i = 0; i < L; i++) begin
                        if (a_lmask[i]) bm = bm | (64'hFF << (8 * i));
                    end
                    mm[mWr][a_addr] = (old & ~bm) | (a_data_i & bm);
                end
            end
            if (a_done && canWrite) begin
                mLevel = mLevel + 1;
                mWr    = 1 - mWr;
            end
            if (b_done && canRead) begin
                mLevel = mLevel - 1;
                mRd    = 1 - mRd;
            end
        end
    endtask

    task automatic applyStimulus(input logic rstn, input logic [1:0] we, input logic [7:0] mask,
                                 input logic [AW-1:0] waddr, input logic [63:0] wdata,
                                 input logic adone, input logic re, input logic [AW-1:0] raddr,
                                 input logic bdone);
        rst_n    = rstn;
        a_we     = we;
        a_lmask  = mask;
        a_addr   = waddr;
        a_data_i = wdata;
        a_done   = adone;
        b_re     = re;
        b_addr   = raddr;
        b_done   = bdone;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b1, 2'b00, 8'h00, '0, 64'd0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic writeWord(input logic [AW-1:0] addr, input logic [1:0] mode,
                             input logic [7:0] mask, input logic [63:0] data);
        applyStimulus(1'b1, mode, mask, addr, data, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic pulseADone();
        applyStimulus(1'b1, 2'b00, 8'h00, '0, 64'd0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic pulseBDone();
        applyStimulus(1'b1, 2'b00, 8'h00, '0, 64'd0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic readWord(input logic [AW-1:0] addr);
        applyStimulus(1'b1, 2'b00, 8'h00, '0, 64'd0, 1'b0, 1'b1, addr, 1'b0);
    endtask

    initial begin
        logic [63:0] v1;
        logic [63:0] v2;
        total    = 0;
        bad      = 0;
        mLevel   = 0;
        mWr      = 0;
        mRd      = 0;
        expData  = 64'd0;
        expValid = 1'b0;

        // Reset state
        applyStimulus(1'b0, 2'b00, 8'h00, '0, 64'd0, 1'b0, 1'b0, '0, 1'b0);
        checkVal("reset_a_rdy", {63'd0, a_rdy}, 64'd1);
        checkVal("reset_b_level", {62'd0, b_level}, 64'd0);

        // Give every word of both banks a known value
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                writeWord(AW'(a), 2'b11, 8'hFF, {$urandom, $urandom});
            end
            pulseADone();
        end
        pulseBDone();
        pulseBDone();

        applyStimulus(1'b0, 2'b00, 8'h00, '0, 64'd0, 1'b0, 1'b0, '0, 1'b0);

        // Full-word write, hand over, read back
        writeWord(9'd5, 2'b11, 8'hFF, 64'h1122334455667788);
        pulseADone();
        readWord(9'd5);
        checkVal("tp1_data", b_data_o, 64'h1122334455667788);
        checkVal("tp1_valid", {63'd0, b_valid_o}, 64'd1);
        checkVal("tp1_level", {62'd0, b_level}, 64'd1);
        pulseBDone();

        // Low half into high lanes
        writeWord(9'd3, 2'b11, 8'hFF, 64'd0);
        writeWord(9'd3, 2'b01, 8'h00, 64'hAAAAAAAA55667788);
        pulseADone();
        readWord(9'd3);
        checkVal("tp2_data", b_data_o, 64'h5566778800000000);
        pulseBDone();

        // Low half into low lanes
        writeWord(9'd3, 2'b11, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
        writeWord(9'd3, 2'b10, 8'h00, 64'h0000000012345678);
        pulseADone();
        readWord(9'd3);
        checkVal("tp3_data", b_data_o, 64'hFFFFFFFF12345678);
        pulseBDone();

        // Masked write touching lanes 7 and 0 only
        writeWord(9'd3, 2'b11, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
        writeWord(9'd3, 2'b11, 8'h81, 64'h0102030405060708);
        writeWord(9'd4, 2'b11, 8'h00, 64'h0102030405060708);
        pulseADone();
        readWord(9'd3);
        checkVal("tp3_mask", b_data_o, 64'h01FFFFFFFFFFFF08);
        pulseBDone();

        // Both banks full: writer stalls, dropped write, ignored a_done
        v1 = 64'hA1A2A3A4A5A6A7A8;
        v2 = 64'hB1B2B3B4B5B6B7B8;
        writeWord(9'd0, 2'b11, 8'hFF, v1);
        pulseADone();
        writeWord(9'd0, 2'b11, 8'hFF, v2);
        pulseADone();
        checkVal("tp4_a_rdy", {63'd0, a_rdy}, 64'd0);
        checkVal("tp4_level", {62'd0, b_level}, 64'd2);
        writeWord(9'd0, 2'b11, 8'hFF, 64'hDEADBEEFDEADBEEF);
        pulseADone();
        checkVal("tp4_level_hold", {62'd0, b_level}, 64'd2);
        readWord(9'd0);
        checkVal("tp4_dropped", b_data_o, v1);
        pulseBDone();
        checkVal("tp4_a_rdy_after", {63'd0, a_rdy}, 64'd1);
        checkVal("tp4_level_after", {62'd0, b_level}, 64'd1);

        // Simultaneous a_done and b_done, then read with b_done
        applyStimulus(1'b1, 2'b00, 8'h00, '0, 64'd0, 1'b1, 1'b0, '0, 1'b1);
        checkVal("tp5_level", {62'd0, b_level}, 64'd1);
        applyStimulus(1'b1, 2'b00, 8'h00, '0, 64'd0, 1'b0, 1'b1, 9'd0, 1'b1);
        checkVal("tp5_data", b_data_o, v1);
        checkVal("tp5_valid", {63'd0, b_valid_o}, 64'd1);
        checkVal("tp5_level0", {62'd0, b_level}, 64'd0);

        // Reset while both banks are full and a read is requested
        pulseADone();
        pulseADone();
        checkVal("tp6_pre_level", {62'd0, b_level}, 64'd2);
        applyStimulus(1'b0, 2'b00, 8'h00, '0, 64'd0, 1'b0, 1'b1, 9'd0, 1'b0);
        checkVal("tp6_valid", {63'd0, b_valid_o}, 64'd0);
        checkVal("tp6_data", b_data_o, 64'd0);
        checkVal("tp6_b_rdy", {63'd0, b_rdy}, 64'd0);
        checkVal("tp6_level", {62'd0, b_level}, 64'd0);
        idle();

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom_range(0, 59) != 0),
                          2'($urandom_range(0, 3)),
                          8'($urandom),
                          AW'($urandom),
                          {$urandom, $urandom},
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 1) == 0),
                          AW'($urandom),
                          ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
